// File: rtl/spi_lite_pkg.sv
// Shared definitions for the SPI-lite core: FSM encoding, bit-order constants and
// a count-width helper used by the TX/RX shifters and the APB register block.
package spi_lite_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } spi_state_e;

  localparam logic ORDER_LSB_FIRST = 1'b1;
  localparam logic ORDER_MSB_FIRST = 1'b0;

  // Bits needed to count 0..value-1; valid for value >= 2.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (((value - 1) >> i) != 0) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/spi_rx_deserializer_if.sv
// Parallel-side bus of the SPI-lite receive deserializer: holding-buffer handshake,
// status and overrun-clear.
interface spi_rx_deserializer_if #(
  parameter int unsigned DATAWIDTH = 8
);
  logic [DATAWIDTH-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 busy;
  logic                 rx_overrun;
  logic                 ovr_clr;

  modport master (
    output rx_data, rx_valid, busy, rx_overrun,
    input  rx_ready, ovr_clr
  );

  modport slave (
    input  rx_data, rx_valid, busy, rx_overrun,
    output rx_ready, ovr_clr
  );
endinterface

// File: rtl/sipo_shifter.sv
// Serial-in parallel-out shift register with selectable direction and synchronous clear.
module sipo_shifter #(
  parameter int unsigned DATAWIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 sh_en,
  input  logic                 dir,
  input  logic                 sdi,
  output logic [DATAWIDTH-1:0] q
);
  import spi_lite_pkg::*;

  logic [DATAWIDTH-1:0] q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (sh_en) begin
      if (dir == ORDER_LSB_FIRST) q_d = {sdi, q_q[DATAWIDTH-1:1]};
      else                        q_d = {q_q[DATAWIDTH-2:0], sdi};
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/spi_rx_deserializer.sv
// SPI-lite receive deserializer: frame FSM, bit counter, one-entry holding buffer.
// Optional sticky overrun flag is built when SPI_RX_OVERRUN_EN is defined.
module spi_rx_deserializer #(
  parameter int unsigned DATAWIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_n,
  input  logic                  frm_en,
  input  logic                  sh_en,
  input  logic                  sh_rl,
  input  logic                  sdi,
  spi_rx_deserializer_if.master rx_if
);
  import spi_lite_pkg::*;

  localparam int unsigned CntW = clog2(DATAWIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(DATAWIDTH - 1);

  spi_state_e state_d, state_q;
  logic [CntW-1:0] bit_cnt_d, bit_cnt_q;
  logic mode_d, mode_q;
  logic [DATAWIDTH-1:0] rx_data_d, rx_data_q;
  logic rx_valid_d, rx_valid_q;
  logic [DATAWIDTH-1:0] shift_q;
  logic [DATAWIDTH-1:0] word_asm;
  logic shift_ok, complete, accept, busy;

  // frm_en low wins over a coincident strobe, so the bit is dropped.
  assign shift_ok = (state_q == ST_SHIFT) && frm_en && sh_en;
  assign complete = shift_ok && (bit_cnt_q == LastBit);
  assign accept   = rx_valid_q && rx_if.rx_ready;

  // Word as it will look once the current sdi is shifted in.
  assign word_asm = (mode_q == ORDER_LSB_FIRST) ? {sdi, shift_q[DATAWIDTH-1:1]}
                                                : {shift_q[DATAWIDTH-2:0], sdi};

  sipo_shifter #(
    .DATAWIDTH(DATAWIDTH)
  ) u_sipo_shifter (
    .clk_i(clk_i),
    .rst_n(rst_n),
    .clr  (state_q == ST_IDLE),
    .sh_en(shift_ok),
    .dir  (mode_q),
    .sdi  (sdi),
    .q    (shift_q)
  );

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (frm_en)  state_d = ST_SHIFT;
      ST_SHIFT: if (!frm_en) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_q == ST_SHIFT);
  end

  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    mode_d     = mode_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;

    if (state_q == ST_IDLE) begin
      bit_cnt_d = '0;
      if (frm_en) mode_d = sh_rl;
    end else if (!frm_en) begin
      bit_cnt_d = '0;
    end else if (shift_ok) begin
      bit_cnt_d = complete ? '0 : bit_cnt_q + 1'b1;
    end

    if (complete && (!rx_valid_q || rx_if.rx_ready)) begin
      rx_data_d  = word_asm;
      rx_valid_d = 1'b1;
    end else if (accept) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q  <= '0;
      mode_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      mode_q     <= mode_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

`ifdef SPI_RX_OVERRUN_EN
  logic overrun;
  logic rx_overrun_d, rx_overrun_q;

  assign overrun = complete && rx_valid_q && !rx_if.rx_ready;

  always_comb begin
    rx_overrun_d = rx_overrun_q;
    if (overrun)              rx_overrun_d = 1'b1;
    else if (rx_if.ovr_clr)   rx_overrun_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) rx_overrun_q <= 1'b0;
    else        rx_overrun_q <= rx_overrun_d;
  end

  assign rx_if.rx_overrun = rx_overrun_q;
`else
  assign rx_if.rx_overrun = 1'b0;
`endif

  assign rx_if.rx_data  = rx_data_q;
  assign rx_if.rx_valid = rx_valid_q;
  assign rx_if.busy     = busy;

endmodule

// File: tb/tb_spi_rx_deserializer.sv
// Directed bench for spi_rx_deserializer (DATAWIDTH=8): table-driven words plus
// back-to-back, overrun, abort and async-reset sequences.
module tb_spi_rx_deserializer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frm_en = 1'b0;
  logic sh_en = 1'b0;
  logic sh_rl = 1'b0;
  logic sdi = 1'b0;

  int checks = 0;
  int errors = 0;

  spi_rx_deserializer_if #(.DATAWIDTH(8)) rx_if ();

  spi_rx_deserializer #(
    .DATAWIDTH(8)
  ) dut (
    .clk_i (clk),
    .rst_n (rst_n),
    .frm_en(frm_en),
    .sh_en (sh_en),
    .sh_rl (sh_rl),
    .sdi   (sdi),
    .rx_if (rx_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] bits;   // bits[7] is sent first
    logic       order;  // 1 = LSB-first
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[5];

`ifdef SPI_RX_OVERRUN_EN
  localparam logic ExpOvr = 1'b1;
`else
  localparam logic ExpOvr = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Entered and left on a negedge; ends with the FSM in SHIFT.
  task automatic begin_frame(input logic order);
    frm_en = 1'b0;
    sh_rl  = order;
    @(negedge clk);
    frm_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] bits, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      sdi   = bits[i];
      sh_en = 1'b1;
      @(negedge clk);
    end
    sh_en = 1'b0;
  endtask

  task automatic consume(input string name);
    rx_if.rx_ready = 1'b1;
    @(negedge clk);
    rx_if.rx_ready = 1'b0;
    check(name, 32'(rx_if.rx_valid), 32'd0);
  endtask

  initial begin
    vecs[0] = '{bits: 8'b10100101, order: 1'b0, exp: 8'hA5};
    vecs[1] = '{bits: 8'b10100101, order: 1'b1, exp: 8'hA5};
    vecs[2] = '{bits: 8'b10000000, order: 1'b1, exp: 8'h01};
    vecs[3] = '{bits: 8'b11000000, order: 1'b1, exp: 8'h03};
    vecs[4] = '{bits: 8'b11000000, order: 1'b0, exp: 8'hC0};

    rx_if.rx_ready = 1'b0;
    rx_if.ovr_clr  = 1'b0;
    @(negedge clk);
    check("reset rx_valid", 32'(rx_if.rx_valid), 32'd0);
    check("reset rx_data", 32'(rx_if.rx_data), 32'd0);
    check("reset busy", 32'(rx_if.busy), 32'd0);
    check("reset rx_overrun", 32'(rx_if.rx_overrun), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // sh_en ignored while idle
    sh_en = 1'b1;
    sdi   = 1'b1;
    @(negedge clk);
    sh_en = 1'b0;
    check("idle strobe rx_valid", 32'(rx_if.rx_valid), 32'd0);

    for (int v = 0; v < 5; v++) begin
      begin_frame(vecs[v].order);
      check($sformatf("vec%0d busy", v), 32'(rx_if.busy), 32'd1);
      send_bits(vecs[v].bits, 8);
      check($sformatf("vec%0d rx_valid", v), 32'(rx_if.rx_valid), 32'd1);
      check($sformatf("vec%0d rx_data", v), 32'(rx_if.rx_data), 32'(vecs[v].exp));
      consume($sformatf("vec%0d consumed", v));
    end

    // Back-to-back words, consumer always ready
    begin_frame(1'b0);
    rx_if.rx_ready = 1'b1;
    send_bits(8'h3C, 8);
    check("b2b first rx_valid", 32'(rx_if.rx_valid), 32'd1);
    check("b2b first rx_data", 32'(rx_if.rx_data), 32'h3C);
    send_bits(8'hC3, 8);
    check("b2b second rx_valid", 32'(rx_if.rx_valid), 32'd1);
    check("b2b second rx_data", 32'(rx_if.rx_data), 32'hC3);
    @(negedge clk);
    rx_if.rx_ready = 1'b0;
    check("b2b drained", 32'(rx_if.rx_valid), 32'd0);
    check("b2b rx_overrun", 32'(rx_if.rx_overrun), 32'd0);

    // Overrun: second word arrives while the first is unread
    begin_frame(1'b0);
    send_bits(8'h11, 8);
    check("ovr first rx_data", 32'(rx_if.rx_data), 32'h11);
    send_bits(8'h22, 8);
    check("ovr rx_valid held", 32'(rx_if.rx_valid), 32'd1);
    check("ovr rx_data kept", 32'(rx_if.rx_data), 32'h11);
    check("ovr flag set", 32'(rx_if.rx_overrun), 32'(ExpOvr));
    rx_if.ovr_clr = 1'b1;
    @(negedge clk);
    rx_if.ovr_clr = 1'b0;
    check("ovr flag cleared", 32'(rx_if.rx_overrun), 32'd0);
    consume("ovr consumed");

    // Abort after 5 bits; a strobe coinciding with frm_en=0 is dropped
    begin_frame(1'b0);
    send_bits(8'hFF, 5);
    frm_en = 1'b0;
    sh_en  = 1'b1;
    @(negedge clk);
    sh_en  = 1'b0;
    check("abort busy low", 32'(rx_if.busy), 32'd0);
    check("abort rx_valid", 32'(rx_if.rx_valid), 32'd0);
    frm_en = 1'b1;
    @(negedge clk);
    sh_rl = 1'b1;  // mid-frame order change must be ignored
    send_bits(8'h5A, 8);
    check("abort word rx_valid", 32'(rx_if.rx_valid), 32'd1);
    check("abort word rx_data", 32'(rx_if.rx_data), 32'h5A);

    // Async reset mid-word, with 8'h5A still unread
    send_bits(8'h00, 3);
    #2 rst_n = 1'b0;
    #1;
    check("async rst rx_valid", 32'(rx_if.rx_valid), 32'd0);
    check("async rst rx_data", 32'(rx_if.rx_data), 32'd0);
    check("async rst busy", 32'(rx_if.busy), 32'd0);
    check("async rst rx_overrun", 32'(rx_if.rx_overrun), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    begin_frame(1'b0);
    send_bits(8'hFF, 8);
    check("post rst rx_valid", 32'(rx_if.rx_valid), 32'd1);
    check("post rst rx_data", 32'(rx_if.rx_data), 32'hFF);
    consume("post rst consumed");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
